// File: rtl/digit_scan_controller_pkg.sv
// Shared types and 7-segment constants for the digit scan controller.
package digit_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/digit_scan_controller_if.sv
// Counter-side inputs and display-side outputs of the digit scan controller.
interface digit_scan_controller_if #(
  parameter int unsigned DIGITS = 6
);

  logic                  ref_clk;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  lz_en;
  logic [6:0]            seg_out;
  logic [DIGITS-1:0]     digit_en;
  logic                  frame_done;

  modport master (
    output ref_clk, bcd_in, lz_en,
    input  seg_out, digit_en, frame_done
  );

  modport slave (
    input  ref_clk, bcd_in, lz_en,
    output seg_out, digit_en, frame_done
  );

endinterface

// File: rtl/digit_scan_controller_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
  import digit_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Standard decimal patterns, dash for 10-15
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_scan_controller.sv
// Multiplexes a snapshotted BCD value onto one shared 7-segment bus with
// per-digit blanking gaps, frame-aligned updates and leading-zero blanking.
module digit_scan_controller
  import digit_scan_pkg::*;
#(
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned DWELL_CYC = 1000,
  parameter int unsigned BLANK_CYC = 24
) (
  input logic                   clk,
  input logic                   rst_n,
  digit_scan_controller_if.slave bus
);

  localparam int unsigned CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic                swap;

  logic [4*DIGITS-1:0] disp_reg, pend_reg, load_val;
  logic                pend_vld;
  logic [DIGITS-1:0]   blank_mask;

  logic [DIGITS-1:0]   sel_n;
  logic [3:0]          cur_bcd;
  logic [6:0]          cur_seg;
  logic                cur_blank;

  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   en_q;
  logic                fd_q;

  // Digit k is blanked when enabled and it and every higher digit are zero;
  // digit 0 is never blanked so a zero value still shows "0".
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v,
                                                input logic en);
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (v[4*k +: 4] == 4'd0);
      lz_mask[k] = en && zero_above;
    end
  endfunction

  // Next scan position; swap marks the final dwell cycle of the frame
  always_comb begin
    swap    = 1'b0;
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = DRIVE;
          cnt_n   = '0;
        end
      end
      DRIVE: begin
        if (cnt == DWELL_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          if (idx == IDX_LAST) begin
            idx_n = '0;
            swap  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
    endcase
  end

  // Outputs are registered from the next-state view, so the single decoder
  // looks at the digit that will be driven in the coming cycle.
  always_comb begin
    sel_n   = '0;
    cur_bcd = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_n == IW'(k)) begin
        sel_n[k] = 1'b1;
        cur_bcd  = disp_reg[4*k +: 4];
      end
    end
    cur_blank = |(sel_n & blank_mask);
  end

  bcd_to_7seg u_dec (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  // Scan FSM, dwell counter, digit index and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
      seg_q <= SEG_OFF;
      en_q  <= '0;
      fd_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      if (state_n == DRIVE) begin
        en_q  <= sel_n;
        seg_q <= cur_blank ? SEG_OFF : cur_seg;
      end else begin
        en_q  <= '0;
        seg_q <= SEG_OFF;
      end
      fd_q <= (state_n == DRIVE) && (idx_n == IDX_LAST) && (cnt_n == DWELL_LAST);
    end
  end

  // A refresh on the swap cycle bypasses the pending slot entirely
  assign load_val = bus.ref_clk ? bus.bcd_in : pend_reg;

  // Snapshot capture and frame-boundary swap onto the display value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg   <= '0;
      pend_vld   <= 1'b0;
      disp_reg   <= '0;
      blank_mask <= '0;
    end else if (swap) begin
      pend_vld <= 1'b0;
      if (bus.ref_clk || pend_vld) begin
        disp_reg   <= load_val;
        blank_mask <= lz_mask(load_val, bus.lz_en);
      end
    end else if (bus.ref_clk) begin
      pend_reg <= bus.bcd_in;
      pend_vld <= 1'b1;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.digit_en   = en_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Self-checking bench: a default-parameter instance checked against a cycle
// table, and a short-frame instance checked every cycle against a model.
module tb_digit_scan_controller;

  localparam int unsigned N    = 6;
  localparam int unsigned B    = 3;
  localparam int unsigned D    = 7;
  localparam int unsigned SLOT = B + D;
  localparam int unsigned F    = N * SLOT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  digit_scan_controller_if #(.DIGITS(N)) bus ();
  digit_scan_controller_if #(.DIGITS(6)) bus_def ();

  digit_scan_controller #(.DIGITS(N), .DWELL_CYC(D), .BLANK_CYC(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  digit_scan_controller #(.DIGITS(6), .DWELL_CYC(1000), .BLANK_CYC(24)) dut_def (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_def)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned t      = 0;

  logic        cur_ref = 1'b0;
  logic [23:0] cur_bcd = '0;
  logic        cur_lz  = 1'b0;

  logic [23:0] m_disp, m_pend;
  logic        m_pv;
  logic [5:0]  m_mask;
  logic [6:0]  seg_tab [16];

  logic        chk_on  = 1'b0;
  logic        chk_def = 1'b0;
  string       chk_name;
  logic [5:0]  chk_en;
  logic [6:0]  chk_seg;
  logic        chk_fd;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  en;
    logic [6:0]  seg;
    logic        fd;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [5:0] model_mask(input logic [23:0] v, input logic lz);
    int unsigned top;
    top = 0;
    for (int unsigned k = 0; k < N; k++)
      if (((v >> (4 * k)) & 24'hF) != 24'h0) top = k;
    model_mask = '0;
    if (lz)
      for (int unsigned k = 1; k < N; k++)
        if (k > top) model_mask[k] = 1'b1;
  endfunction

  function automatic logic [23:0] rand_bcd();
    int unsigned n;
    logic [3:0]  dg;
    rand_bcd = '0;
    n = $urandom_range(0, 6);
    for (int unsigned k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) dg = 4'($urandom_range(10, 15));
      else                           dg = 4'($urandom_range(0, 9));
      rand_bcd[4*k +: 4] = dg;
    end
  endfunction

  task automatic check(input string name, input logic [5:0] en, input logic [6:0] seg,
                       input logic fd, input logic [5:0] ee, input logic [6:0] es,
                       input logic ef);
    n_chk++;
    if (en !== ee || seg !== es || fd !== ef) begin
      n_fail++;
      $display("FAIL %s t=%0d: got en=%b seg=%h fd=%b, expected en=%b seg=%h fd=%b",
               name, t, en, seg, fd, ee, es, ef);
    end
  endtask

  task automatic model_reset();
    m_disp = '0;
    m_pend = '0;
    m_pv   = 1'b0;
    m_mask = '0;
    t      = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance it
  task automatic tick();
    int unsigned pos, slot, off;
    logic [5:0]  e_en;
    logic [6:0]  e_seg;
    logic        e_fd;
    logic [3:0]  dg;
    @(negedge clk);
    bus.ref_clk = cur_ref;
    bus.bcd_in  = cur_bcd;
    bus.lz_en   = cur_lz;
    pos  = t % F;
    slot = pos / SLOT;
    off  = pos % SLOT;
    e_en  = '0;
    e_seg = '0;
    e_fd  = 1'b0;
    if (off >= B) begin
      dg    = 4'(m_disp >> (4 * slot));
      e_en  = 6'(6'd1 << slot);
      e_seg = m_mask[slot] ? 7'h00 : seg_tab[dg];
      e_fd  = (slot == N - 1) && (off == SLOT - 1);
    end
    check("scan", bus.digit_en, bus.seg_out, bus.frame_done, e_en, e_seg, e_fd);
    n_chk++;
    if (!$onehot0(bus.digit_en)) begin
      n_fail++;
      $display("FAIL onehot0 t=%0d: got digit_en=%b, required at most one bit set", t, bus.digit_en);
    end
    if (chk_on) begin
      if (chk_def)
        check(chk_name, bus_def.digit_en, bus_def.seg_out, bus_def.frame_done,
              chk_en, chk_seg, chk_fd);
      else
        check(chk_name, bus.digit_en, bus.seg_out, bus.frame_done,
              chk_en, chk_seg, chk_fd);
      chk_on = 1'b0;
    end
    @(posedge clk);
    if (pos == F - 1) begin
      if (cur_ref) begin
        m_disp = cur_bcd;
        m_mask = model_mask(cur_bcd, cur_lz);
        m_pv   = 1'b0;
      end else if (m_pv) begin
        m_disp = m_pend;
        m_mask = model_mask(m_pend, cur_lz);
        m_pv   = 1'b0;
      end
    end else if (cur_ref) begin
      m_pend = cur_bcd;
      m_pv   = 1'b1;
    end
    t++;
  endtask

  task automatic goto_pos(input int unsigned p);
    while (t % F != p) tick();
  endtask

  task automatic expect_at(input int unsigned p, input string name, input logic [5:0] en,
                           input logic [6:0] seg, input logic fd);
    goto_pos(p);
    chk_on   = 1'b1;
    chk_def  = 1'b0;
    chk_name = name;
    chk_en   = en;
    chk_seg  = seg;
    chk_fd   = fd;
    tick();
  endtask

  task automatic pulse(input logic [23:0] v);
    cur_bcd = v;
    cur_ref = 1'b1;
    tick();
    cur_ref = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    tbl[0] = '{0,    6'b000000, 7'h00, 1'b0};
    tbl[1] = '{23,   6'b000000, 7'h00, 1'b0};
    tbl[2] = '{24,   6'b000001, 7'h3F, 1'b0};
    tbl[3] = '{1023, 6'b000001, 7'h3F, 1'b0};
    tbl[4] = '{1024, 6'b000000, 7'h00, 1'b0};
    tbl[5] = '{1048, 6'b000010, 7'h3F, 1'b0};
    tbl[6] = '{6142, 6'b100000, 7'h3F, 1'b0};
    tbl[7] = '{6143, 6'b100000, 7'h3F, 1'b1};
    tbl[8] = '{6144, 6'b000000, 7'h00, 1'b0};

    bus.ref_clk     = 1'b0;
    bus.bcd_in      = '0;
    bus.lz_en       = 1'b0;
    bus_def.ref_clk = 1'b0;
    bus_def.bcd_in  = '0;
    bus_def.lz_en   = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Default-parameter timing from reset release, no refresh
    for (int unsigned i = 0; i < 9; i++) begin
      while (t < tbl[i].cyc) tick();
      chk_on   = 1'b1;
      chk_def  = 1'b1;
      chk_name = $sformatf("def_cyc%0d", tbl[i].cyc);
      chk_en   = tbl[i].en;
      chk_seg  = tbl[i].seg;
      chk_fd   = tbl[i].fd;
      tick();
    end

    // Mid-frame snapshot only appears after the next frame boundary
    cur_lz = 1'b0;
    goto_pos(20);
    pulse(24'h123456);
    expect_at(44, "hold_d4", 6'b010000, 7'h3F, 1'b0);
    expect_at(3,  "new_d0",  6'b000001, 7'h7D, 1'b0);
    expect_at(59, "new_d5",  6'b100000, 7'h06, 1'b1);

    // Leading-zero suppression
    cur_lz = 1'b1;
    goto_pos(20);
    pulse(24'h000042);
    expect_at(3,  "lz_d0", 6'b000001, 7'h5B, 1'b0);
    expect_at(13, "lz_d1", 6'b000010, 7'h66, 1'b0);
    expect_at(23, "lz_d2", 6'b000100, 7'h00, 1'b0);
    expect_at(53, "lz_d5", 6'b100000, 7'h00, 1'b0);
    goto_pos(20);
    pulse(24'h000000);
    expect_at(3,  "zero_d0", 6'b000001, 7'h3F, 1'b0);
    expect_at(14, "zero_d1", 6'b000010, 7'h00, 1'b0);

    // Latest capture wins; refresh on the swap cycle loads directly
    cur_lz = 1'b0;
    goto_pos(10);
    pulse(24'h000001);
    goto_pos(30);
    pulse(24'h000002);
    expect_at(3, "last_wins", 6'b000001, 7'h5B, 1'b0);
    goto_pos(15);
    pulse(24'h000003);
    goto_pos(59);
    pulse(24'h000007);
    expect_at(3,  "swap_ref_d0", 6'b000001, 7'h07, 1'b0);
    expect_at(13, "swap_ref_d1", 6'b000010, 7'h3F, 1'b0);

    // Non-decimal code shows a dash
    goto_pos(20);
    pulse(24'h00000C);
    expect_at(3, "dash", 6'b000001, 7'h40, 1'b0);

    // Randomized refreshes and live-value changes
    for (int unsigned i = 0; i < 30 * F; i++) begin
      if (t % F == F / 2 && $urandom_range(0, 3) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 15) == 0) begin
        cur_bcd = rand_bcd();
        cur_ref = 1'b1;
      end else begin
        cur_ref = 1'b0;
        if ($urandom_range(0, 3) == 0) cur_bcd = rand_bcd();
      end
      tick();
    end
    cur_ref = 1'b0;

    // Asynchronous reset during digit 3 drive with a snapshot pending
    cur_lz = 1'b1;
    goto_pos(10);
    pulse(24'h999999);
    goto_pos(35);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst", bus.digit_en, bus.seg_out, bus.frame_done, 6'b0, 7'h00, 1'b0);
    check("async_rst_def", bus_def.digit_en, bus_def.seg_out, bus_def.frame_done,
          6'b0, 7'h00, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    expect_at(3,  "restart_d0", 6'b000001, 7'h3F, 1'b0);
    expect_at(13, "restart_d1", 6'b000010, 7'h3F, 1'b0);
    repeat (2 * F) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
